// File: rtl/fifo_pkg.sv
// Definitions shared by the read- and write-side FIFO controllers:
// default widths, pointer width and the skid-buffer state encoding.
package fifo_pkg;

  localparam int FIFO_AW = 8;
  localparam int FIFO_DW = 8;
  localparam int FIFO_PW = FIFO_AW + 1;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } buf_state_t;

  // The state encoding doubles as the number of words held.
  function automatic logic [1:0] state_count(input buf_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer between the RAM read port and the downstream
// VLD/RDY handshake; entry "head" is always the oldest word.
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          cap,
  input  logic [DW-1:0] cap_data,
  input  logic          rdy,
  output logic [DW-1:0] dout,
  output logic          vld,
  output logic          pop,
  output logic [1:0]    cnt
);

  buf_state_t    state, state_nxt;
  logic [DW-1:0] head, tail;
  logic [1:0]    cnt_nxt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= B0;
    else        state <= state_nxt;
  end

  always_comb begin
    cnt_nxt   = state_count(state) + {1'b0, cap} - {1'b0, pop};
    state_nxt = state;
    case (cnt_nxt)
      2'd0:    state_nxt = B0;
      2'd1:    state_nxt = B1;
      default: state_nxt = B2;
    endcase
  end

  always_comb begin
    vld  = (state != B0);
    pop  = vld && rdy;
    cnt  = state_count(state);
    dout = head;
  end

  // Capture lands behind whatever survives this cycle's pop.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (state == B0) head <= cap_data;
          else             tail <= cap_data;
        end
        2'b01: head <= tail;
        2'b11: begin
          if (state == B1) begin
            head <= cap_data;
          end else begin
            head <= tail;
            tail <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: read pointer, empty/TC flags and RAM read issue.
// Optional LEVEL/AE outputs are built when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int AW     = FIFO_AW,
  parameter int DW     = FIFO_DW,
  parameter int AE_THR = 2
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic [AW:0]   WPTR,
  output logic [AW-1:0] RADDR,
  output logic          REN,
  input  logic [DW-1:0] RDATA,
  output logic [DW-1:0] DOUT,
  output logic          VLD,
  input  logic          RDY,
  output logic [AW:0]   RPTR,
  output logic          EMPTY,
  output logic          TC,
  output logic [AW+1:0] LEVEL,
  output logic          AE
);

  localparam int PW = AW + 1;
  localparam int LW = AW + 2;

  logic [PW-1:0] rptr;
  logic          inf;
  logic          pop;
  logic          mem_empty;
  logic [1:0]    cnt;
  logic [2:0]    committed;

  fifo_skid2 #(.DW(DW)) u_skid (
    .clk      (CLK),
    .clr_n    (CLR_N),
    .cap      (inf),
    .cap_data (RDATA),
    .rdy      (RDY),
    .dout     (DOUT),
    .vld      (VLD),
    .pop      (pop),
    .cnt      (cnt)
  );

  assign mem_empty = (WPTR == rptr);

  // Only issue a read if the buffer will have room when its data arrives.
  assign committed = {1'b0, cnt} + {2'b00, inf} - {2'b00, pop};
  assign REN       = !mem_empty && (committed < 3'd2);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      rptr <= '0;
      inf  <= 1'b0;
    end else begin
      inf <= REN;
      if (REN) rptr <= rptr + PW'(1);
    end
  end

  assign RADDR = rptr[AW-1:0];
  assign RPTR  = rptr;
  assign TC    = &rptr[AW-1:0];
  assign EMPTY = mem_empty && !inf && (cnt == 2'd0);

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] diff;
  assign diff  = WPTR - rptr;
  assign LEVEL = {1'b0, diff} + {{PW{1'b0}}, inf} + {{(PW-1){1'b0}}, cnt};
  assign AE    = (LEVEL <= LW'(AE_THR));
`else
  assign LEVEL = '0;
  assign AE    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl (AW=3, DW=8): directed scenarios plus random traffic
// checked every cycle against a word-queue model; honours FIFO_RD_LEVEL_EN.
module tb_fifo_rd_ctrl;

  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int AE_THR = 2;
  localparam int DEPTH  = 8;
  localparam int PMOD   = 16;

  logic          CLK = 1'b0;
  logic          CLR_N = 1'b0;
  logic [AW:0]   WPTR = '0;
  logic [AW-1:0] RADDR;
  logic          REN;
  logic [DW-1:0] RDATA = '0;
  logic [DW-1:0] DOUT;
  logic          VLD;
  logic          RDY = 1'b0;
  logic [AW:0]   RPTR;
  logic          EMPTY;
  logic          TC;
  logic [AW+1:0] LEVEL;
  logic          AE;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] wq [$];
  int wcount = 0;

  int mRptr = 0;
  int mInf = 0;
  int mCnt = 0;
  int expRen = 0;
  int expPop = 0;

  always #5 CLK = ~CLK;

  fifo_rd_ctrl #(.AW(AW), .DW(DW), .AE_THR(AE_THR)) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .WPTR  (WPTR),
    .RADDR (RADDR),
    .REN   (REN),
    .RDATA (RDATA),
    .DOUT  (DOUT),
    .VLD   (VLD),
    .RDY   (RDY),
    .RPTR  (RPTR),
    .EMPTY (EMPTY),
    .TC    (TC),
    .LEVEL (LEVEL),
    .AE    (AE)
  );

  // RAM read port with one cycle of latency.
  always @(posedge CLK) begin
    if (REN) RDATA <= ram[RADDR];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words travel RAM -> in flight -> buffer; the queue holds their order.
  always @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      mRptr <= 0;
      mInf  <= 0;
      mCnt  <= 0;
      wq.delete();
    end else begin
      if (expPop != 0 && wq.size() > 0) void'(wq.pop_front());
      mCnt  <= mCnt + mInf - expPop;
      mInf  <= expRen;
      mRptr <= (mRptr + expRen) % PMOD;
    end
  end

  always @(negedge CLK) begin
    int wp;
    int lvl;
    bit memEmpty;
    if (!CLR_N) begin
      expRen = 0;
      expPop = 0;
      checkOutput("rst_vld", VLD, 0);
      checkOutput("rst_dout", DOUT, 0);
      checkOutput("rst_ren", REN, 0);
      checkOutput("rst_rptr", RPTR, 0);
      checkOutput("rst_empty", EMPTY, 1);
      checkOutput("rst_tc", TC, 0);
    end else begin
      wp = int'(WPTR);
      memEmpty = (wp == mRptr);
      expPop = (mCnt > 0 && RDY) ? 1 : 0;
      expRen = (!memEmpty && (mCnt + mInf - expPop < 2)) ? 1 : 0;
      lvl = ((wp - mRptr + PMOD) % PMOD) + mInf + mCnt;
      checkOutput("ren", REN, expRen);
      checkOutput("rptr", RPTR, mRptr);
      checkOutput("raddr", RADDR, mRptr % DEPTH);
      checkOutput("vld", VLD, (mCnt > 0) ? 1 : 0);
      checkOutput("empty", EMPTY, (memEmpty && mInf == 0 && mCnt == 0) ? 1 : 0);
      checkOutput("tc", TC, (mRptr % DEPTH == DEPTH - 1) ? 1 : 0);
      checkOutput("cap_pop_in_b2", {31'd0, dut.inf && dut.cnt == 2'd2 && dut.pop}, 0);
      if (mCnt > 0) begin
        if (wq.size() > 0) checkOutput("dout", DOUT, wq[0]);
        else checkOutput("dout_no_word", 1, 0);
      end
`ifdef FIFO_RD_LEVEL_EN
      checkOutput("level", LEVEL, lvl);
      checkOutput("ae", AE, (lvl <= AE_THR) ? 1 : 0);
`else
      checkOutput("level_tied", LEVEL, 0);
      checkOutput("ae_tied", AE, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic writeWord(input logic [DW-1:0] data);
    if (((wcount - mRptr + PMOD) % PMOD) < DEPTH) begin
      ram[wcount % DEPTH] = data;
      wcount = (wcount + 1) % PMOD;
      WPTR = wcount[AW:0];
      wq.push_back(data);
    end
  endtask

  task automatic applyReset();
    @(posedge CLK);
    #1;
    CLR_N = 1'b0;
    WPTR = '0;
    wcount = 0;
    RDY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    CLR_N = 1'b1;
  endtask

  task automatic applyStimulus(input int nWrites, input logic rdy);
    RDY = rdy;
    for (int i = 0; i < nWrites; i++) writeWord(DW'($urandom));
  endtask

  initial begin
    int renCount;

    // Idle after reset
    applyReset();
    repeat (5) @(negedge CLK);
    checkOutput("idle_ren", REN, 0);
    checkOutput("idle_vld", VLD, 0);
    checkOutput("idle_empty", EMPTY, 1);
    checkOutput("idle_rptr", RPTR, 0);
    tick();

    // Single word, latency two cycles
    RDY = 1'b1;
    writeWord(8'hA5);
    @(negedge CLK);
    checkOutput("single_ren", REN, 1);
    tick();
    @(negedge CLK);
    checkOutput("single_vld_t1", VLD, 0);
    tick();
    @(negedge CLK);
    checkOutput("single_vld_t2", VLD, 1);
    checkOutput("single_dout", DOUT, 8'hA5);
    checkOutput("single_rptr", RPTR, 1);
    tick();
    @(negedge CLK);
    checkOutput("single_empty_after", EMPTY, 1);
    checkOutput("single_vld_after", VLD, 0);

    // Backpressure with four words queued
    applyReset();
    RDY = 1'b0;
    for (int i = 0; i < 4; i++) writeWord(8'h10 + 8'(i));
    renCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      renCount += int'(REN);
      tick();
    end
    checkOutput("bp_ren_pulses", renCount, 2);
    checkOutput("bp_rptr", RPTR, 2);
    checkOutput("bp_vld", VLD, 1);
    checkOutput("bp_dout", DOUT, 8'h10);
    RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("bp_drain_vld", VLD, 1);
      checkOutput("bp_drain_dout", DOUT, 8'h10 + i);
      tick();
    end
    @(negedge CLK);
    checkOutput("bp_final_rptr", RPTR, 4);
    checkOutput("bp_final_vld", VLD, 0);

    // Pointer wrap
    applyReset();
    RDY = 1'b1;
    for (int i = 0; i < 7; i++) writeWord(8'h70 + 8'(i));
    repeat (12) tick();
    checkOutput("wrap_pre_rptr", RPTR, 7);
    checkOutput("wrap_pre_empty", EMPTY, 1);
    writeWord(8'hC0);
    writeWord(8'hC1);
    @(negedge CLK);
    checkOutput("wrap_tc_hi", TC, 1);
    checkOutput("wrap_raddr7", RADDR, 7);
    checkOutput("wrap_ren7", REN, 1);
    tick();
    @(negedge CLK);
    checkOutput("wrap_tc_lo", TC, 0);
    checkOutput("wrap_raddr0", RADDR, 0);
    checkOutput("wrap_rptr8", RPTR, 8);
    tick();
    @(negedge CLK);
    checkOutput("wrap_rptr9", RPTR, 9);
    checkOutput("wrap_ren_off", REN, 0);
    repeat (3) tick();

    // Reset while a read is in flight and one word is buffered
    applyReset();
    RDY = 1'b0;
    writeWord(8'h55);
    writeWord(8'h66);
    tick();
    tick();
    checkOutput("mid_pre_vld", VLD, 1);
    CLR_N = 1'b0;
    WPTR = '0;
    wcount = 0;
    #1;
    checkOutput("mid_rst_vld", VLD, 0);
    checkOutput("mid_rst_dout", DOUT, 0);
    checkOutput("mid_rst_ren", REN, 0);
    checkOutput("mid_rst_rptr", RPTR, 0);
    checkOutput("mid_rst_empty", EMPTY, 1);
    repeat (2) @(posedge CLK);
    #1;
    CLR_N = 1'b1;
    RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("mid_post_vld", VLD, 0);
      tick();
    end

`ifdef FIFO_RD_LEVEL_EN
    // Level and almost-empty
    applyReset();
    RDY = 1'b0;
    for (int i = 0; i < 3; i++) writeWord(8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("lvl_three", LEVEL, 3);
      checkOutput("lvl_ae_lo", AE, 0);
      tick();
    end
    RDY = 1'b1;
    tick();
    RDY = 1'b0;
    @(negedge CLK);
    checkOutput("lvl_two", LEVEL, 2);
    checkOutput("lvl_ae_hi", AE, 1);
`endif

    // Random traffic
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) applyReset();
      applyStimulus(int'($urandom_range(0, 2)), ($urandom_range(0, 3) != 0));
      if ((c / 200) % 3 == 2) RDY = ($urandom_range(0, 3) == 0);
      tick();
    end
    RDY = 1'b1;
    repeat (20) tick();
    @(negedge CLK);
    checkOutput("final_empty", EMPTY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
